// File: rtl/ram_responder.sv
// ram_responder: single-port storage that answers CS/WE/OE bus accesses
// over a shared tri-state data bus, with a fixed number of wait states.
//
// Ports
//   clk      : sole clock, all state changes on the rising edge
//   reset    : synchronous, active-high; returns the control path to IDLE
//   CS       : chip select; an access stays open while it is high
//   WE / OE  : write / read request, qualified by CS (exactly one must be set)
//   address  : byte address from the bus initiator
//   data     : shared tri-state data bus (driven only while returning read data)
//   READY    : access complete (read data valid / write committed)
//   ERR      : the completed access targeted an address beyond the storage
//
// Each access runs IDLE -> BUSY (WAIT_STATES extra cycles) -> RESP.
// Address, operation and write data are latched when the access opens, so
// later bus activity cannot disturb an access in flight. RESP is held until
// CS drops, and the initiator has to release CS before the next access.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module ram_responder #(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int ADDR_WIDTH  = 2 * `DATA_WIDTH,
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  WE,
  input  logic                  OE,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  READY,
  output logic                  ERR
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    mem_we;
  logic                    oor;
  logic                    drive_bus;
  logic [MEM_AW-1:0]       idx;
  logic [DATA_WIDTH-1:0]   mem_q [2**MEM_AW];

  // Any latched address bit at or above MEM_AW marks the access out of
  // range; low bits index storage directly, so there is no aliasing.
  assign oor = |(addr_q >> MEM_AW);
  assign idx = addr_q[MEM_AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // Both or neither request asserted is not a valid access.
        if (CS && (WE ^ OE)) begin
          addr_d  = address;
          wr_d    = WE;
          wdata_d = WE ? data : wdata_q;
          cnt_d   = WAIT_CNT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!CS) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (wr_q) begin
            mem_we = !oor;
          end else begin
            rdata_d = oor ? '1 : mem_q[idx];
          end
          state_d = RESP;
        end
      end
      RESP: begin
        // Holding CS here never reopens an access; only CS low leaves RESP.
        if (!CS) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request fields; only consulted outside IDLE, so no reset needed.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  // Storage keeps its contents through reset; a write racing reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign READY     = (state_q == RESP);
  assign ERR       = READY && oor;
  assign drive_bus = READY && !wr_q && CS && OE;
  assign data      = drive_bus ? rdata_q : 'z;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed bench for ram_responder. A WAIT_STATES=2 and a
// WAIT_STATES=0 instance share the control inputs; each has its own data
// bus with a pull-up, so a released bus reads as all ones.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic        oe;
  logic [15:0] address;
  logic [7:0]  tb_drv;
  logic        tb_drv_en;
  tri1  [7:0]  data_bus;
  tri1  [7:0]  data_bus0;
  logic        ready;
  logic        err;
  logic        ready0;
  logic        err0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign data_bus  = tb_drv_en ? tb_drv : 'z;
  assign data_bus0 = tb_drv_en ? tb_drv : 'z;

  ram_responder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_AW(8), .WAIT_STATES(2)
  ) dut (
    .clk(clk), .reset(reset), .CS(cs), .WE(we), .OE(oe),
    .address(address), .data(data_bus), .READY(ready), .ERR(err)
  );

  ram_responder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_AW(8), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .reset(reset), .CS(cs), .WE(we), .OE(oe),
    .address(address), .data(data_bus0), .READY(ready0), .ERR(err0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Opens an access at the current negedge and waits for READY. lat is the
  // number of edges after the sample edge at which READY was seen (-1 on
  // timeout). Address and write data are scrambled once the access is open.
  task automatic start_acc(input bit sel0, input bit is_wr, input logic [15:0] addr,
                           input logic [7:0] wd, output int lat);
    cs        = 1'b1;
    we        = is_wr;
    oe        = ~is_wr;
    address   = addr;
    tb_drv    = wd;
    tb_drv_en = is_wr;
    lat       = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) begin
        address = ~addr;
        tb_drv  = ~wd;
      end
      if ((sel0 ? ready0 : ready) == 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic end_acc(input bit sel0);
    cs        = 1'b0;
    we        = 1'b0;
    oe        = 1'b0;
    tb_drv_en = 1'b0;
    @(negedge clk);
    check_val("ready_drop", 32'(sel0 ? ready0 : ready), 0);
    @(negedge clk);
  endtask

  task automatic access(input bit sel0, input bit is_wr, input logic [15:0] addr,
                        input logic [7:0] wd, output int lat,
                        output logic [7:0] rd, output logic er);
    start_acc(sel0, is_wr, addr, wd, lat);
    rd = sel0 ? data_bus0 : data_bus;
    er = sel0 ? err0 : err;
    end_acc(sel0);
  endtask

  initial begin
    int         lat;
    logic [7:0] rd;
    logic       er;

    reset = 1'b1; cs = 1'b0; we = 1'b0; oe = 1'b0;
    address = '0; tb_drv = '0; tb_drv_en = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 32'(ready), 0);
    check_val("rst_err", 32'(err), 0);
    check_val("rst_bus", 32'(data_bus), 'hFF);
    reset = 1'b0;
    @(negedge clk);

    // Write 0x5A to 0x0034, read it back: READY 3 edges after sampling.
    access(0, 1, 'h0034, 'h5A, lat, rd, er);
    check_val("wr34_lat", 32'(lat), 3);
    check_val("wr34_err", 32'(er), 0);
    access(0, 0, 'h0034, 'h00, lat, rd, er);
    check_val("rd34_lat", 32'(lat), 3);
    check_val("rd34_data", 32'(rd), 'h5A);
    check_val("rd34_err", 32'(er), 0);

    // Invalid requests (both or neither strobe) are ignored; bus stays released.
    cs = 1'b1; we = 1'b1; oe = 1'b1; address = 'h0034;
    repeat (5) begin
      @(negedge clk);
      check_val("both_ready", 32'(ready), 0);
      check_val("both_bus", 32'(data_bus), 'hFF);
    end
    we = 1'b0; oe = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("none_ready", 32'(ready), 0);
    end
    cs = 1'b0;
    @(negedge clk);

    // Out-of-range address: ERR with READY, reads all ones, no aliasing to 0.
    access(0, 1, 'h0000, 'h3C, lat, rd, er);
    check_val("wr00_err", 32'(er), 0);
    access(0, 1, 'h0100, 'h77, lat, rd, er);
    check_val("wr100_lat", 32'(lat), 3);
    check_val("wr100_err", 32'(er), 1);
    access(0, 0, 'h0100, 'h00, lat, rd, er);
    check_val("rd100_data", 32'(rd), 'hFF);
    check_val("rd100_err", 32'(er), 1);
    access(0, 0, 'h0000, 'h00, lat, rd, er);
    check_val("rd00_data", 32'(rd), 'h3C);
    check_val("rd00_err", 32'(er), 0);

    // Write aborted one edge into BUSY is never performed.
    access(0, 1, 'h0020, 'h99, lat, rd, er);
    cs = 1'b1; we = 1'b1; address = 'h0020; tb_drv = 'h11; tb_drv_en = 1'b1;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; tb_drv_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_val("abort_ready", 32'(ready), 0);
    end
    access(0, 0, 'h0020, 'h00, lat, rd, er);
    check_val("rd20_data", 32'(rd), 'h99);

    // RESP holds while CS stays high; no new access is opened.
    start_acc(0, 0, 'h0034, 'h00, lat);
    check_val("hold_lat", 32'(lat), 3);
    repeat (3) begin
      @(negedge clk);
      check_val("hold_ready", 32'(ready), 1);
      check_val("hold_data", 32'(data_bus), 'h5A);
    end
    end_acc(0);

    // Reset during BUSY discards the pending write of 0x22 to 0x0034.
    cs = 1'b1; we = 1'b1; address = 'h0034; tb_drv = 'h22; tb_drv_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rstbusy_ready", 32'(ready), 0);
    reset = 1'b0; cs = 1'b0; we = 1'b0; tb_drv_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in RESP of a read: READY drops and the bus is released at once.
    start_acc(0, 0, 'h0034, 'h00, lat);
    check_val("rstresp_data", 32'(data_bus), 'h5A);
    reset = 1'b1;
    @(negedge clk);
    check_val("rstresp_ready", 32'(ready), 0);
    check_val("rstresp_err", 32'(err), 0);
    check_val("rstresp_bus", 32'(data_bus), 'hFF);
    reset = 1'b0; cs = 1'b0; oe = 1'b0;
    repeat (2) @(negedge clk);
    access(0, 0, 'h0034, 'h00, lat, rd, er);
    check_val("rd34_after_rst", 32'(rd), 'h5A);

    // Zero wait states: READY one edge after the sample edge.
    access(1, 1, 'h0010, 'hC3, lat, rd, er);
    check_val("ws0_wr_lat", 32'(lat), 1);
    access(1, 0, 'h0010, 'h00, lat, rd, er);
    check_val("ws0_rd_lat", 32'(lat), 1);
    check_val("ws0_rd_data", 32'(rd), 'hC3);
    check_val("ws0_rd_err", 32'(er), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH, SHALL set the data bus width.
REQ-002 Parameter ADDR_WIDTH, default 2*`DATA_WIDTH, SHALL set the address bus width.
REQ-003 Parameter MEM_AW, default 8, SHALL set implemented storage to 2**MEM_AW words of DATA_WIDTH bits (MEM_AW <= ADDR_WIDTH).
REQ-004 Parameter WAIT_STATES, default 1, SHALL set the extra busy cycles per access (range 0..15).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 CS  input  1  chip select; an access is open while high.
REQ-008 WE  input  1  write request, qualified by CS.
REQ-009 OE  input  1  read request, qualified by CS.
REQ-010 address  input  ADDR_WIDTH  byte address from the bus initiator (PC or address register).
REQ-011 data  inout  DATA_WIDTH  shared tri-state data bus.
REQ-012 READY  output  1  access complete; read data valid or write committed.
REQ-013 ERR  output  1  completed access targeted an address >= 2**MEM_AW.

Function
REQ-014 The block SHALL be an FSM with states IDLE, BUSY, RESP.
REQ-015 In IDLE, on an edge with CS=1 and exactly one of WE/OE=1: latch address, operation and (for writes) data; load wait counter with WAIT_STATES; go to BUSY.
REQ-016 In IDLE, CS=1 with WE=OE=1 or WE=OE=0 SHALL be ignored (remain IDLE, no latch).
REQ-017 In BUSY, with counter nonzero and CS=1, the counter SHALL decrement by 1 per edge.
REQ-018 In BUSY, with counter zero and CS=1: perform the access (write mem[addr] or load read register from mem[addr]); go to RESP.
REQ-019 Request sampled at edge k SHALL give READY=1 from edge k+WAIT_STATES+1 (WAIT_STATES=0: edge k+1).
REQ-020 In BUSY, CS=0 at any edge SHALL abort: go to IDLE, write not performed, READY stays 0.
REQ-021 In RESP, READY=1 SHALL hold while CS=1; the first edge with CS=0 SHALL return to IDLE with READY=0.
REQ-022 data SHALL be driven only in RESP for a read while CS=1 and OE=1; high-impedance otherwise, including all of IDLE and BUSY.
REQ-023 WE/OE/address/data changes during BUSY or RESP SHALL be ignored; latched values govern the access.
REQ-024 Back-to-back accesses SHALL need at least one IDLE cycle with CS=0 between them; CS held high from RESP never reopens an access.
REQ-025 Out of range (any latched address bit at or above MEM_AW set): read returns all ones, write discarded, ERR=1 alongside READY in RESP.
REQ-026 ERR SHALL be 0 whenever READY is 0.
REQ-027 Address bits below MEM_AW SHALL index storage directly; no wrap or aliasing for out-of-range addresses.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, READY=0, ERR=0, wait counter 0, read register 0, data bus released, from any state.
REQ-029 Reset during BUSY SHALL discard the pending write; storage contents SHALL NOT be cleared by reset.
REQ-030 reset SHALL take priority over CS/WE/OE on the same edge.

Verification (DATA_WIDTH=8, ADDR_WIDTH=16, MEM_AW=8, WAIT_STATES=2)
REQ-031 Write 0x5A to 0x0034 (CS=1,WE=1 held); then read 0x0034 -> READY 3 edges after each sample edge; data=0x5A in read RESP; ERR=0.
REQ-032 WAIT_STATES=0 build, read 0x0010 after writing 0xC3 -> READY 1 edge after sample edge, data=0xC3.
REQ-033 Write 0x77 to 0x0100 -> ERR=1 with READY; read 0x0100 returns 0xFF with ERR=1; read 0x0000 unaffected.
REQ-034 Write 0x11 to 0x0020, drop CS 1 edge into BUSY -> READY never asserts; later read of 0x0020 returns prior contents.
REQ-035 CS=1 with WE=OE=1 for 5 cycles -> stays IDLE, READY=0, data bus Z throughout.
REQ-036 Reset pulsed in RESP of a read of 0x0034 -> next cycle READY=0, bus Z; subsequent read of 0x0034 still returns 0x5A.
